vend_input_conditioner: RTL

- Front-end stage of the vending machine. Takes the raw, asynchronous coin-acceptor and select-button signals.
- Synchronises and debounces both inputs, then converts each clean press into a single-cycle pulse.
- Drives the vending FSM's m (coin) and a (select) inputs.
- Guarantees m and a are never high in the same cycle, so simultaneous events are serialised instead of dropped.

---
 rtl/vend_pkg.sv | 19 +
 rtl/vend_debounce.sv | 62 ++++++
 rtl/vend_input_conditioner.sv | 68 ++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared constants for the vending machine front end and its neighbours.
package vend_pkg;

  // Default number of consecutive stable cycles before a level change is accepted.
  localparam int DEBOUNCE_DEFAULT = 16;

  // Credit counter width used by the neighbouring vending FSM.
  localparam int CREDIT_W = 3;

  // Event kinds presented to the vending FSM.
  typedef enum logic {
    EV_COIN = 1'b0,
    EV_BTN  = 1'b1
  } vend_event_e;

  // Coin wins a same-cycle contest so credit is registered before selection.
  localparam vend_event_e EV_PRIORITY = EV_COIN;

endpackage

// File: rtl/vend_debounce.sv
// One input channel: 2-FF synchroniser, debounce counter, stable level and
// a single-cycle rise indication on every accepted 0->1 change.
module vend_debounce
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_d;
  logic             sync_q;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser for the asynchronous contact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_d <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      sync_d <= raw;
      sync_q <= sync_d;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive mismatching cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync_q == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= sync_q;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Delayed copy of the stable level for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_d <= 1'b0;
    end else begin
      stable_d <= stable;
    end
  end

  assign level = stable;
  assign rise  = stable & ~stable_d;

endmodule

// File: rtl/vend_input_conditioner.sv
// Front end of the vending machine: debounces the coin and button contacts
// and issues one-cycle m / a pulses, never both in the same cycle. A button
// event that loses to a coin event is held pending and issued next cycle.
module vend_input_conditioner
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic coin_raw,
  input  logic btn_raw,
  input  logic en,
  output logic m,
  output logic a,
  output logic coin_lvl,
  output logic btn_lvl
);

  logic rise_c;
  logic rise_b;
  logic pend_c;
  logic pend_b;
  logic coin_cand;
  logic btn_cand;
  logic coin_win;
  logic btn_win;

  vend_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_coin (
    .clk   (clk),
    .reset (reset),
    .raw   (coin_raw),
    .level (coin_lvl),
    .rise  (rise_c)
  );

  vend_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_raw),
    .level (btn_lvl),
    .rise  (rise_b)
  );

  // Candidates: a held pending event, or a fresh rise while enabled.
  always_comb begin
    coin_cand = pend_c | (rise_c & en);
    btn_cand  = pend_b | (rise_b & en);
    coin_win  = coin_cand & ((EV_PRIORITY == EV_COIN) | ~btn_cand);
    btn_win   = btn_cand & ~coin_win;
  end

  // Pending flags keep losing candidates; outputs are registered pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_c <= 1'b0;
      pend_b <= 1'b0;
      m      <= 1'b0;
      a      <= 1'b0;
    end else begin
      pend_c <= coin_cand & ~coin_win;
      pend_b <= btn_cand & ~btn_win;
      m      <= coin_win;
      a      <= btn_win;
    end
  end

endmodule
